btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 164 ++++++++++++++++
 tb/tb_btn_debounce.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Push-button conditioner. The raw, asynchronous, active-low button is
// synchronised through two flip-flops, debounced by requiring DB_CYCLES
// consecutive samples that disagree with the current debounced level, and
// then fed to a small press/hold FSM. The FSM produces one-cycle pulses for
// an accepted press, an accepted release and a long press, plus a wrapping
// 8-bit count of accepted presses.
//
// Parameters
//   DB_CYCLES    consecutive stable samples needed to accept a change (>=2)
//   LONG_CYCLES  held cycles after acceptance before long_press     (>=2)
//
// Ports
//   clk_i         system clock, everything on the rising edge
//   rst_ni        synchronous active-low reset
//   btn_ni        raw push button, asynchronous, 0 = pressed
//   pressed_o     debounced button level, 1 = pressed
//   press_o       one-cycle pulse on an accepted press
//   release_o     one-cycle pulse on an accepted release
//   long_press_o  one-cycle pulse when a press has been held LONG_CYCLES
//   press_cnt_o   accepted press count, modulo 256
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DB_CYCLES   = 500000,
    parameter int unsigned LONG_CYCLES = 50000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_ni,
    output logic       pressed_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_press_o,
    output logic [7:0] press_cnt_o
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES);
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_e;

    logic              syncA_q;
    logic              syncB_q;
    logic              btnSample;
    logic [DB_W-1:0]   dbCnt_q;
    logic [DB_W-1:0]   dbCnt_d;
    logic              pressed_q;
    logic              pressed_d;
    logic              acceptEdge;

    state_e            state_q;
    logic [LONG_W-1:0] holdCnt_q;
    logic              press_q;
    logic              release_q;
    logic              longPress_q;
    logic [7:0]        pressCnt_q;

    // Second synchroniser stage, inverted so that 1 means "button down".
    assign btnSample = ~syncB_q;

    // Debounce qualification. Any sample agreeing with the current
    // debounced level restarts the count, so only an unbroken run of
    // DB_CYCLES disagreeing samples flips the level. acceptEdge marks the
    // edge on which the flip happens so the FSM can react in the same cycle.
    always_comb begin
        dbCnt_d    = dbCnt_q;
        pressed_d  = pressed_q;
        acceptEdge = 1'b0;
        if (btnSample == pressed_q) begin
            dbCnt_d = '0;
        end else if (dbCnt_q == DB_LAST) begin
            pressed_d  = btnSample;
            dbCnt_d    = '0;
            acceptEdge = 1'b1;
        end else begin
            dbCnt_d = dbCnt_q + DB_W'(1);
        end
    end

    // Synchroniser and debounce registers. The synchroniser resets to the
    // released level so a button held through reset is seen as a fresh
    // press once reset lifts.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            syncA_q   <= 1'b1;
            syncB_q   <= 1'b1;
            dbCnt_q   <= '0;
            pressed_q <= 1'b0;
        end else begin
            syncA_q   <= btn_ni;
            syncB_q   <= syncA_q;
            dbCnt_q   <= dbCnt_d;
            pressed_q <= pressed_d;
        end
    end

    // Press/hold FSM with registered pulse outputs. In IDLE the debounced
    // level is low, so an accept there is always a press; in HELD/LONG it
    // is always a release. The release check comes first in HELD so that a
    // release landing on the long-press edge suppresses the long pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            holdCnt_q   <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            longPress_q <= 1'b0;
            pressCnt_q  <= 8'd0;
        end else begin
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            longPress_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acceptEdge) begin
                        state_q    <= HELD;
                        press_q    <= 1'b1;
                        pressCnt_q <= pressCnt_q + 8'd1;
                        holdCnt_q  <= '0;
                    end
                end
                HELD: begin
                    if (acceptEdge) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        holdCnt_q <= '0;
                    end else if (holdCnt_q == LONG_LAST) begin
                        state_q     <= LONG;
                        longPress_q <= 1'b1;
                    end else begin
                        holdCnt_q <= holdCnt_q + LONG_W'(1);
                    end
                end
                LONG: begin
                    if (acceptEdge) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        holdCnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    holdCnt_q <= '0;
                end
            endcase
        end
    end

    assign pressed_o    = pressed_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = longPress_q;
    assign press_cnt_o  = pressCnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
//
// Self-checking bench for btn_debounce with DB_CYCLES=4, LONG_CYCLES=10.
// Every clock edge is compared against a behavioural model that works from
// the button's rules: the synchronised sample is the button value from two
// edges earlier, the level flips after DB_CYCLES consecutive disagreeing
// samples, and a long press fires LONG_CYCLES edges after the press edge.
// A fixed vector table and several hand-written sequences add checks
// against literal expected values.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int DB   = 4;
    localparam int LONG = 10;

    logic       clk;
    logic       rst_n;
    logic       btn_n;
    logic       pressed;
    logic       press;
    logic       rel;
    logic       longPress;
    logic [7:0] pressCnt;

    int checks = 0;
    int errors = 0;

    btn_debounce #(
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .btn_ni      (btn_n),
        .pressed_o   (pressed),
        .press_o     (press),
        .release_o   (rel),
        .long_press_o(longPress),
        .press_cnt_o (pressCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit mHist[$];
    bit mPressed;
    int mRun;
    int mHold;
    bit mLongDone;
    int mCnt;
    bit mPress;
    bit mRel;
    bit mLong;

    typedef struct {
        logic       rstN;
        logic       btnN;
        logic       expPressed;
        logic       expPress;
        logic       expRel;
        logic       expLong;
        logic [7:0] expCnt;
    } vec_t;

    vec_t vecs[16];

    // Advance the model by one clock edge with the given inputs.
    task automatic modelStep(input logic r, input logic b);
        bit s;
        mPress = 0;
        mRel   = 0;
        mLong  = 0;
        if (!r) begin
            mHist     = {1'b1, 1'b1};
            mPressed  = 0;
            mRun      = 0;
            mHold     = 0;
            mLongDone = 0;
            mCnt      = 0;
        end else begin
            s = ~mHist[0];
            void'(mHist.pop_front());
            mHist.push_back(b);
            if (s != mPressed) begin
                mRun++;
                if (mRun == DB) begin
                    mPressed = s;
                    mRun     = 0;
                    if (s) begin
                        mPress    = 1;
                        mCnt      = (mCnt + 1) % 256;
                        mHold     = 0;
                        mLongDone = 0;
                    end else begin
                        mRel = 1;
                    end
                end else if (mPressed && !mLongDone) begin
                    mHold++;
                    if (mHold == LONG) begin
                        mLong     = 1;
                        mLongDone = 1;
                    end
                end
            end else begin
                mRun = 0;
                if (mPressed && !mLongDone) begin
                    mHold++;
                    if (mHold == LONG) begin
                        mLong     = 1;
                        mLongDone = 1;
                    end
                end
            end
        end
    endtask

    // Single comparison with reporting.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive inputs away from the clock edge, step one edge, compare with model.
    task automatic applyStimulus(input logic r, input logic b);
        @(negedge clk);
        rst_n = r;
        btn_n = b;
        @(posedge clk);
        #1;
        modelStep(r, b);
        checkOutput("pressed",    {7'd0, pressed},   {7'd0, mPressed});
        checkOutput("press",      {7'd0, press},     {7'd0, mPress});
        checkOutput("release",    {7'd0, rel},       {7'd0, mRel});
        checkOutput("long_press", {7'd0, longPress}, {7'd0, mLong});
        checkOutput("press_cnt",  pressCnt,          8'(mCnt));
        checkOutput("exclusive",  {7'd0, (press & rel) | (press & longPress) | (rel & longPress)}, 8'd0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1);
    endtask

    initial begin
        int pressAt;
        int longAt;
        int longSeen;
        int runLen;
        logic lvl;

        rst_n = 1'b0;
        btn_n = 1'b1;

        // Clean press then release (table-driven, literal expectations)
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

        $display("[TB] table: clean press and release");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].btnN);
            checkOutput($sformatf("vec%0d.pressed", i), {7'd0, pressed},   {7'd0, vecs[i].expPressed});
            checkOutput($sformatf("vec%0d.press", i),   {7'd0, press},     {7'd0, vecs[i].expPress});
            checkOutput($sformatf("vec%0d.release", i), {7'd0, rel},       {7'd0, vecs[i].expRel});
            checkOutput($sformatf("vec%0d.long", i),    {7'd0, longPress}, {7'd0, vecs[i].expLong});
            checkOutput($sformatf("vec%0d.cnt", i),     pressCnt,          vecs[i].expCnt);
        end

        $display("[TB] bounce rejection");
        doReset();
        idle(4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        idle(8);
        checkOutput("bounce.pressed", {7'd0, pressed}, 8'd0);
        checkOutput("bounce.cnt", pressCnt, 8'd0);

        $display("[TB] long hold");
        pressAt  = -1;
        longAt   = -1;
        longSeen = 0;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (press) pressAt = i;
            if (longPress) begin
                longAt = i;
                longSeen++;
            end
        end
        checkOutput("long.pressAt", 8'(pressAt), 8'd6);
        checkOutput("long.count", 8'(longSeen), 8'd1);
        checkOutput("long.delay", 8'(longAt - pressAt), 8'(LONG));
        idle(10);
        checkOutput("long.released", {7'd0, pressed}, 8'd0);

        $display("[TB] release coinciding with long-press edge");
        // press at edge 6, long due at edge 16; first high at edge 11
        // gives release acceptance at edge 16
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b0);
        longSeen = 0;
        for (int i = 11; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (longPress) longSeen++;
            if (i == 16) checkOutput("coincide.release", {7'd0, rel}, 8'd1);
        end
        checkOutput("coincide.noLong", 8'(longSeen), 8'd0);

        $display("[TB] press counter wrap");
        doReset();
        idle(4);
        for (int p = 1; p <= 256; p++) begin
            for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
            for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
            if (p == 255) checkOutput("wrap.255", pressCnt, 8'd255);
            if (p == 256) checkOutput("wrap.0", pressCnt, 8'd0);
        end

        $display("[TB] reset mid-hold");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rstHold.pressed", {7'd0, pressed}, 8'd0);
        checkOutput("rstHold.cnt", pressCnt, 8'd0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (i == 5) checkOutput("rstHold.noEarly", {7'd0, press}, 8'd0);
            if (i == 6) begin
                checkOutput("rstHold.press", {7'd0, press}, 8'd1);
                checkOutput("rstHold.cnt1", pressCnt, 8'd1);
            end
        end
        idle(8);

        $display("[TB] randomized run");
        lvl = 1'b1;
        for (int seg = 0; seg < 250; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(1'b0, lvl);
            end
            lvl    = ~lvl;
            runLen = $urandom_range(1, 20);
            for (int i = 0; i < runLen; i++) applyStimulus(1'b1, lvl);
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
